// File: rtl/tx_scheduler.sv
// tx_scheduler: two-requester round-robin message scheduler feeding a UART
// transmitter byte stream.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req[1:0]        level requests, bit i = requester i
//   msg_id0/1       message select for requester 0/1 (0 OK, 1 FAIL, 2 HELP, 3 STATUS)
//   gnt[1:0]        one-cycle grant pulse for the winning requester
//   duty_cycle      live duty value (snapshotted at grant, saturated to 99)
//   pow2, pow5      live POW2/POW5 values (snapshotted at grant)
//   tx_data         byte presented to the UART transmitter
//   tx_valid        tx_data valid
//   tx_ready        transmitter accepts the presented byte this cycle
//   busy            high from the grant cycle through the post-message gap
module tx_scheduler #(
    parameter int unsigned CRLF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] msg_id0,
    input  logic [1:0] msg_id1,
    output logic [1:0] gnt,
    input  logic [6:0] duty_cycle,
    input  logic [1:0] pow2,
    input  logic [1:0] pow5,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    // Message bodies, right-justified: byte i of an N-byte body sits at
    // bits [8*(N-1-i) +: 8].
    localparam logic [191:0] S_OK   = {176'd0, "OK"};
    localparam logic [191:0] S_FAIL = {160'd0, "FAIL"};
    localparam logic [191:0] S_HELP = "HELP STATUS DC POW2 POW5";
    localparam logic [191:0] S_STAT = {72'd0, "DC=00 P2=0 P5=0"};

    state_t     state_q, state_d;
    logic [4:0] idx_q,   idx_d;
    logic [1:0] gnt_q,   gnt_d;
    logic       prio_q,  prio_d;    // requester favoured when both request
    logic [1:0] id_q,    id_d;
    logic [3:0] tens_q,  tens_d;
    logic [3:0] ones_q,  ones_d;
    logic [1:0] p2_q,    p2_d;
    logic [1:0] p5_q,    p5_d;

    logic [4:0] body_len;
    logic [4:0] last_idx;
    logic [6:0] dc_sat;
    logic       win;
    logic [7:0] body_byte;
    logic [7:0] cur_byte;

    function automatic logic [7:0] pick(input logic [191:0] s,
                                        input logic [4:0]   len,
                                        input logic [4:0]   i);
        logic [7:0]   sh;
        logic [191:0] t;
        sh = {len - i - 5'd1, 3'b000};
        t  = s >> sh;
        return t[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gnt_q   <= '0;
            prio_q  <= 1'b0;
            id_q    <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            p2_q    <= '0;
            p5_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            p2_q    <= p2_d;
            p5_q    <= p5_d;
        end
    end

    assign dc_sat = (duty_cycle > 7'd99) ? 7'd99 : duty_cycle;

    always_comb begin
        case (id_q)
            2'd0:    body_len = 5'd2;
            2'd1:    body_len = 5'd4;
            2'd2:    body_len = 5'd24;
            default: body_len = 5'd15;
        endcase
    end

    assign last_idx = (CRLF != 0) ? body_len + 5'd1 : body_len;

    always_comb begin
        body_byte = 8'h00;
        case (id_q)
            2'd0: body_byte = pick(S_OK,   body_len, idx_q);
            2'd1: body_byte = pick(S_FAIL, body_len, idx_q);
            2'd2: body_byte = pick(S_HELP, body_len, idx_q);
            default: begin
                // Template holds ASCII '0' (0x30) at each digit slot, so the
                // snapshotted digit drops straight into the low nibble.
                body_byte = pick(S_STAT, body_len, idx_q);
                case (idx_q)
                    5'd3:    body_byte[3:0] = tens_q;
                    5'd4:    body_byte[3:0] = ones_q;
                    5'd9:    body_byte[3:0] = {2'b00, p2_q};
                    5'd14:   body_byte[3:0] = {2'b00, p5_q};
                    default: ;
                endcase
            end
        endcase
    end

    always_comb begin
        if (idx_q < body_len)
            cur_byte = body_byte;
        else if ((CRLF != 0) && (idx_q == body_len))
            cur_byte = 8'h0D;
        else
            cur_byte = 8'h0A;
    end

    // The grant cycle stays in IDLE with gnt_q set; that registered pulse is
    // what moves the FSM into SEND, giving the first byte one cycle after gnt.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gnt_d   = '0;
        prio_d  = prio_q;
        id_d    = id_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        p2_d    = p2_q;
        p5_d    = p5_q;
        win     = (req == 2'b11) ? prio_q : req[1];
        case (state_q)
            IDLE: begin
                if (gnt_q != 2'b00) begin
                    state_d = SEND;
                    idx_d   = '0;
                end else if (req != 2'b00) begin
                    gnt_d  = win ? 2'b10 : 2'b01;
                    prio_d = ~win;
                    id_d   = win ? msg_id1 : msg_id0;
                    tens_d = 4'(dc_sat / 7'd10);
                    ones_d = 4'(dc_sat % 7'd10);
                    p2_d   = pow2;
                    p5_d   = pow5;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = GAP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt      = gnt_q;
    assign tx_valid = (state_q == SEND);
    assign tx_data  = tx_valid ? cur_byte : 8'h00;
    assign busy     = (state_q != IDLE) || (gnt_q != 2'b00);

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler (CRLF = 1): table of message vectors
// plus hand-written round-robin and mid-message reset sequences.
module tb_tx_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] msg_id0;
    logic [1:0] msg_id1;
    logic [1:0] gnt;
    logic [6:0] duty_cycle;
    logic [1:0] pow2;
    logic [1:0] pow5;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    tx_scheduler #(.CRLF(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .msg_id0    (msg_id0),
        .msg_id1    (msg_id1),
        .gnt        (gnt),
        .duty_cycle (duty_cycle),
        .pow2       (pow2),
        .pow5       (pow5),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]   req;
        logic [1:0]   id;
        logic [6:0]   duty;
        logic [1:0]   p2;
        logic [1:0]   p5;
        logic         toggle;
        logic [1:0]   exp_gnt;
        logic [207:0] exp_str;
        int unsigned  exp_len;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_exp(input logic [207:0] s, input int unsigned n);
        logic [207:0] t;
        exp_q.delete();
        for (int unsigned k = 0; k < n; k++) begin
            t = s >> (8 * (n - 1 - k));
            exp_q.push_back(t[7:0]);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = 2'b00;
        tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset gnt",      32'(gnt),      32'h0);
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset tx_data",  32'(tx_data),  32'h0);
        check("reset busy",     32'(busy),     32'h0);
        rst = 1'b0;
    endtask

    // Called at a negedge with req already driven. Expects a grant on the
    // next edge, then the bytes in exp_q, one GAP cycle, then IDLE.
    task automatic expect_msg(input logic [1:0] exp_gnt, input bit toggle,
                              input bit hold, input string tag);
        int unsigned waited;
        int unsigned i;
        int unsigned guard;
        bit          rdy;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == 2'b00 && waited < 20);
        check({tag, " gnt"},         32'(gnt),      32'(exp_gnt));
        check({tag, " gnt latency"}, waited,        32'd1);
        check({tag, " busy@gnt"},    32'(busy),     32'h1);
        check({tag, " valid@gnt"},   32'(tx_valid), 32'h0);
        // Inputs changed after the grant must not affect the message.
        duty_cycle = 7'd50;
        pow2       = ~pow2;
        pow5       = ~pow5;
        if (!hold) begin
            req     = 2'b00;
            msg_id0 = ~msg_id0;
            msg_id1 = ~msg_id1;
        end
        @(negedge clk);
        check({tag, " gnt pulse"}, 32'(gnt), 32'h0);
        i     = 0;
        guard = 0;
        rdy   = 1'b1;
        while (i < exp_q.size() && guard < 200) begin
            check($sformatf("%s byte%0d", tag, i), 32'({tx_valid, tx_data}),
                  32'({1'b1, exp_q[i]}));
            tx_ready = rdy;
            if (rdy) i++;
            if (toggle) rdy = !rdy;
            guard++;
            @(negedge clk);
        end
        check({tag, " byte count"}, i, exp_q.size());
        tx_ready = 1'b1;
        check({tag, " gap valid"}, 32'(tx_valid), 32'h0);
        check({tag, " gap busy"},  32'(busy),     32'h1);
        @(negedge clk);
        check({tag, " idle busy"},  32'(busy),     32'h0);
        check({tag, " idle valid"}, 32'(tx_valid), 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        req        = 2'b00;
        msg_id0    = 2'd0;
        msg_id1    = 2'd0;
        duty_cycle = 7'd0;
        pow2       = 2'd0;
        pow5       = 2'd0;
        tx_ready   = 1'b1;

        vecs[0] = '{2'b01, 2'd0, 7'd0,   2'd0, 2'd0, 1'b0, 2'b01,
                    208'({"OK", 8'h0D, 8'h0A}), 4};
        vecs[1] = '{2'b10, 2'd1, 7'd0,   2'd0, 2'd0, 1'b0, 2'b10,
                    208'({"FAIL", 8'h0D, 8'h0A}), 6};
        vecs[2] = '{2'b01, 2'd2, 7'd0,   2'd0, 2'd0, 1'b1, 2'b01,
                    208'({"HELP STATUS DC POW2 POW5", 8'h0D, 8'h0A}), 26};
        vecs[3] = '{2'b10, 2'd3, 7'd7,   2'd2, 2'd3, 1'b0, 2'b10,
                    208'({"DC=07 P2=2 P5=3", 8'h0D, 8'h0A}), 17};
        vecs[4] = '{2'b01, 2'd3, 7'd120, 2'd0, 2'd1, 1'b0, 2'b01,
                    208'({"DC=99 P2=0 P5=1", 8'h0D, 8'h0A}), 17};
        vecs[5] = '{2'b10, 2'd3, 7'd99,  2'd3, 2'd0, 1'b0, 2'b10,
                    208'({"DC=99 P2=3 P5=0", 8'h0D, 8'h0A}), 17};
        vecs[6] = '{2'b01, 2'd3, 7'd100, 2'd1, 2'd1, 1'b1, 2'b01,
                    208'({"DC=99 P2=1 P5=1", 8'h0D, 8'h0A}), 17};
        vecs[7] = '{2'b10, 2'd3, 7'd0,   2'd0, 2'd0, 1'b0, 2'b10,
                    208'({"DC=00 P2=0 P5=0", 8'h0D, 8'h0A}), 17};
        vecs[8] = '{2'b01, 2'd3, 7'd45,  2'd3, 2'd2, 1'b0, 2'b01,
                    208'({"DC=45 P2=3 P5=2", 8'h0D, 8'h0A}), 17};

        // Table of single-requester messages.
        do_reset();
        for (int v = 0; v < 9; v++) begin
            duty_cycle = vecs[v].duty;
            pow2       = vecs[v].p2;
            pow5       = vecs[v].p5;
            if (vecs[v].req[0]) begin
                msg_id0 = vecs[v].id;
                msg_id1 = ~vecs[v].id;
            end else begin
                msg_id1 = vecs[v].id;
                msg_id0 = ~vecs[v].id;
            end
            load_exp(vecs[v].exp_str, vecs[v].exp_len);
            req = vecs[v].req;
            expect_msg(vecs[v].exp_gnt, vecs[v].toggle, 1'b0, $sformatf("vec%0d", v));
        end

        // Round robin with both requests held from reset.
        do_reset();
        msg_id0 = 2'd1;
        msg_id1 = 2'd0;
        req     = 2'b11;
        load_exp(208'({"FAIL", 8'h0D, 8'h0A}), 6);
        expect_msg(2'b01, 1'b0, 1'b1, "rr1");
        load_exp(208'({"OK", 8'h0D, 8'h0A}), 4);
        expect_msg(2'b10, 1'b0, 1'b1, "rr2");
        load_exp(208'({"FAIL", 8'h0D, 8'h0A}), 6);
        expect_msg(2'b01, 1'b0, 1'b0, "rr3");

        // Reset during the third byte of HELP.
        do_reset();
        msg_id0 = 2'd2;
        req     = 2'b01;
        @(negedge clk);
        check("rst gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge clk);
        check("rst byte0", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h48}));
        @(negedge clk);
        check("rst byte1", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h45}));
        @(negedge clk);
        check("rst byte2", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h4C}));
        rst = 1'b1;
        #1;
        check("rst async valid", 32'(tx_valid), 32'h0);
        check("rst async data",  32'(tx_data),  32'h0);
        check("rst async busy",  32'(busy),     32'h0);
        check("rst async gnt",   32'(gnt),      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("post-rst quiet%0d", c), 32'({gnt, tx_valid, busy}), 32'h0);
        end
        msg_id1 = 2'd1;
        req     = 2'b10;
        load_exp(208'({"FAIL", 8'h0D, 8'h0A}), 6);
        expect_msg(2'b10, 1'b0, 1'b0, "post-rst msg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
